// File: rtl/icache_pkg.sv
// icache shared definitions: flags, widths, FSM encoding.
// Imported by the interface, the line store and the top.
package icache_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int ADDR_W    = 32;
  localparam int INSTR_W   = 32;
  localparam int DATA_W    = 32;

  localparam logic [ADDR_W-1:0] NULL32 = 32'h0;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [DATA_W-1:0]  data_t;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_FILL = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the icache.
// slave: the cache itself; master: IF stage plus memory controller.
interface icache_if;
  import icache_pkg::*;

  logic   if_req;
  addr_t  if_addr;
  logic   if_valid;
  instr_t if_instr;
  logic   mc_read_signal;
  addr_t  mc_addr;
  instr_t mc_instr;
  logic   mc_success;

  modport slave (
    input  if_req, if_addr, mc_instr, mc_success,
    output if_valid, if_instr, mc_read_signal, mc_addr
  );

  modport master (
    output if_req, if_addr, mc_instr, mc_success,
    input  if_valid, if_instr, mc_read_signal, mc_addr
  );

endinterface

// File: rtl/icache_line_store.sv
// Tag, valid and data arrays of the direct-mapped icache.
// Combinational lookup, synchronous word write and valid set/clear.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int INDEX_BITS       = 6,
  parameter int OFFSET_WORDS_LOG = 2,
  parameter int TAG_W = ADDR_W - INDEX_BITS - OFFSET_WORDS_LOG - 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INDEX_BITS-1:0]       rd_index,
  input  logic [OFFSET_WORDS_LOG-1:0] rd_offset,
  input  logic [TAG_W-1:0]            rd_tag,
  output logic                        rd_hit,
  output data_t                       rd_word,
  input  logic                        wr_en,
  input  logic [INDEX_BITS-1:0]       wr_index,
  input  logic [OFFSET_WORDS_LOG-1:0] wr_offset,
  input  data_t                       wr_word,
  input  logic                        inv_en,
  input  logic [INDEX_BITS-1:0]       inv_index,
  input  logic                        set_en,
  input  logic [INDEX_BITS-1:0]       set_index,
  input  logic [TAG_W-1:0]            set_tag
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_WORDS_LOG;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  data_t            data_q [LINES][WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (inv_en) valid_q[inv_index] <= FALSE;
      if (set_en) valid_q[set_index] <= TRUE;
    end
  end

  // Payload arrays need no reset: valid gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_index][wr_offset] <= wr_word;
    if (set_en) tag_q[set_index] <= set_tag;
  end

  assign rd_hit  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
  assign rd_word = data_q[rd_index][rd_offset];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache, 1-cycle hit, line fill
// over the memory controller read handshake.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS       = 6,
  parameter int OFFSET_WORDS_LOG = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  input  logic     clr,
  icache_if.slave  bus
);

  localparam int IDX_LO = OFFSET_WORDS_LOG + 2;
  localparam int TAG_LO = IDX_LO + INDEX_BITS;
  localparam int TAG_W  = ADDR_W - TAG_LO;

  typedef logic [OFFSET_WORDS_LOG-1:0] off_t;
  typedef logic [INDEX_BITS-1:0]       idx_t;
  typedef logic [TAG_W-1:0]            tag_t;

  icache_state_e state_q, state_d;

  logic [ADDR_W-1:IDX_LO] line_q;
  off_t   req_off_q;
  off_t   cnt_q;
  logic   drop_q;
  instr_t cap_q;
  logic   if_valid_q;
  instr_t if_instr_q;

  idx_t   req_idx;
  off_t   req_off;
  tag_t   req_tag;
  idx_t   fill_idx;
  tag_t   fill_tag;
  logic   hit;
  data_t  hit_word;
  logic   accept;
  logic   miss;
  logic   fill_wr;
  logic   fill_last;
  logic   upd;
  logic   unused_lo;

  assign req_off   = bus.if_addr[IDX_LO-1:2];
  assign req_idx   = bus.if_addr[TAG_LO-1:IDX_LO];
  assign req_tag   = bus.if_addr[ADDR_W-1:TAG_LO];
  assign fill_idx  = line_q[TAG_LO-1:IDX_LO];
  assign fill_tag  = line_q[ADDR_W-1:TAG_LO];
  assign unused_lo = ^bus.if_addr[1:0];
  assign upd       = rdy && !rst;

  icache_line_store #(
    .INDEX_BITS       (INDEX_BITS),
    .OFFSET_WORDS_LOG (OFFSET_WORDS_LOG)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (req_idx),
    .rd_offset (req_off),
    .rd_tag    (req_tag),
    .rd_hit    (hit),
    .rd_word   (hit_word),
    .wr_en     (upd && fill_wr),
    .wr_index  (fill_idx),
    .wr_offset (cnt_q),
    .wr_word   (bus.mc_instr),
    .inv_en    (upd && miss),
    .inv_index (req_idx),
    .set_en    (upd && fill_last),
    .set_index (fill_idx),
    .set_tag   (fill_tag)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ICACHE_IDLE;
    else if (rdy) state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = FALSE;
    miss      = FALSE;
    fill_wr   = FALSE;
    fill_last = FALSE;
    unique case (state_q)
      ICACHE_IDLE: begin
        accept = bus.if_req && !clr && !if_valid_q;
        if (accept && !hit) begin
          miss    = TRUE;
          state_d = ICACHE_FILL;
        end
      end
      ICACHE_FILL: begin
        if (bus.mc_success) begin
          fill_wr = TRUE;
          if (&cnt_q) begin
            fill_last = TRUE;
            state_d   = ICACHE_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q     <= '0;
      req_off_q  <= '0;
      cnt_q      <= '0;
      drop_q     <= FALSE;
      cap_q      <= NULL32;
      if_valid_q <= FALSE;
      if_instr_q <= NULL32;
    end else if (rdy) begin
      if_valid_q <= FALSE;
      if (accept && hit) begin
        if_valid_q <= TRUE;
        if_instr_q <= hit_word;
      end
      if (miss) begin
        line_q    <= bus.if_addr[ADDR_W-1:IDX_LO];
        req_off_q <= req_off;
        cnt_q     <= '0;
        drop_q    <= FALSE;
      end
      if (state_q == ICACHE_FILL && clr) drop_q <= TRUE;
      if (fill_wr) begin
        if (cnt_q == req_off_q) cap_q <= bus.mc_instr;
        if (fill_last) begin
          // Last-offset requests never see their word in cap_q.
          if (!drop_q && !clr) begin
            if_valid_q <= TRUE;
            if_instr_q <= (cnt_q == req_off_q) ? bus.mc_instr : cap_q;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // Drop the request in the success cycle so it is never re-sampled.
  assign bus.mc_read_signal = (state_q == ICACHE_FILL) && !bus.mc_success;
  assign bus.mc_addr        = {line_q, cnt_q, 2'b00};
  assign bus.if_valid       = if_valid_q;
  assign bus.if_instr       = if_instr_q;

endmodule
